// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains a show-ahead FIFO onto an async serial line, gapless across frames
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       fifo_empty_in,
  input  logic [7:0] fifo_rdata_in,
  output logic       fifo_read_out,
  output logic       txd_out,
  output logic       busy_out
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic stop_cnt;
  logic bit_end;
  logic frame_end;
  assign bit_end = baud == B_LAST;
  assign frame_end = state == STOP && bit_end && (STOP_BITS == 1 || stop_cnt);
  // Pop in any idle cycle, or in the final stop cycle to chain the next frame without a gap.
  assign fifo_read_out = ~reset_in & ~fifo_empty_in & (state == IDLE | frame_end);
  // Frame sequencer; txd is registered, so each transition loads the next line level.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= IDLE;
      txd_out  <= 1'b1;
      busy_out <= 1'b0;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      stop_cnt <= 1'b0;
    end else begin
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE:
          if (fifo_read_out) begin
            shreg    <= fifo_rdata_in;
            state    <= START;
            txd_out  <= 1'b0;
            busy_out <= 1'b1;
          end
        START:
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            txd_out <= shreg[0];
          end
        DATA:
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              txd_out  <= 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              txd_out <= shreg[1];
            end
          end
        default:
          if (frame_end) begin
            if (fifo_read_out) begin
              shreg   <= fifo_rdata_in;
              state   <= START;
              txd_out <= 1'b0;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
      endcase
    end
  end
endmodule
